// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter and its holding buffers.
package regfile_write_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int STARVE_W = 4;

    localparam logic [ADDR_W-1:0]   ZERO_ADDR  = '0;
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/regfile_write_arbiter_hold_buffer.sv
// One-entry writeback holding register; writes to the zero register are accepted and discarded.
module wb_hold_buffer #(
    parameter int DATA_W = regfile_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W = regfile_write_arbiter_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    output logic              full,
    output logic              accept,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data
);
    import regfile_write_arbiter_pkg::*;

    hold_state_t state;

    // A granted entry leaves at this edge, so the slot can be refilled in the same cycle.
    assign in_ready = (state == HOLD_EMPTY) || grant;
    assign accept   = in_valid && in_ready && (in_addr != ADDR_W'(ZERO_ADDR));
    assign full     = (state == HOLD_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HOLD_EMPTY;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (accept) begin
            state    <= HOLD_FULL;
            buf_addr <= in_addr;
            buf_data <= in_data;
        end else if (grant) begin
            state    <= HOLD_EMPTY;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto one registered register-file write port,
// with anti-starvation for A and read-after-write hazard flags.
module regfile_write_arbiter #(
    parameter int DATA_W       = regfile_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W       = regfile_write_arbiter_pkg::ADDR_W,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              busy
);
    import regfile_write_arbiter_pkg::*;

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic              a_full, b_full;
    logic              a_accept, b_accept;
    logic [ADDR_W-1:0] a_buf_addr, b_buf_addr;
    logic [DATA_W-1:0] a_buf_data, b_buf_data;
    logic              grant_a, grant_b;
    logic [STARVE_W-1:0] starve_cnt;
    logic              b_older;

    wb_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hold_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .in_addr  (a_addr),
        .in_data  (a_data),
        .grant    (grant_a),
        .full     (a_full),
        .accept   (a_accept),
        .buf_addr (a_buf_addr),
        .buf_data (a_buf_data)
    );

    wb_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hold_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .in_addr  (b_addr),
        .in_data  (b_data),
        .grant    (grant_b),
        .full     (b_full),
        .accept   (b_accept),
        .buf_addr (b_buf_addr),
        .buf_data (b_buf_data)
    );

    // Same-address conflicts must drain oldest first so the later write lands last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_full && b_full) begin
            if (a_buf_addr == b_buf_addr) begin
                grant_a = !b_older;
            end else begin
                grant_a = (starve_cnt >= LIMIT);
            end
            grant_b = !grant_a;
        end else begin
            grant_a = a_full;
            grant_b = b_full;
        end
    end

    // b_older is only set when A refills behind a B entry that remains buffered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            b_older    <= 1'b0;
        end else begin
            if (!a_full || grant_a) begin
                starve_cnt <= '0;
            end else if (grant_b && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (a_accept || b_accept) begin
                b_older <= a_accept && !b_accept && b_full && !grant_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_a || grant_b;
            if (grant_a) begin
                rf_waddr <= a_buf_addr;
                rf_wdata <= a_buf_data;
            end else if (grant_b) begin
                rf_waddr <= b_buf_addr;
                rf_wdata <= b_buf_data;
            end
        end
    end

    assign hazard1 = (rd_addr1 != ADDR_W'(ZERO_ADDR)) &&
                     ((a_full && (rd_addr1 == a_buf_addr)) ||
                      (b_full && (rd_addr1 == b_buf_addr)) ||
                      (rf_we  && (rd_addr1 == rf_waddr)));

    assign hazard2 = (rd_addr2 != ADDR_W'(ZERO_ADDR)) &&
                     ((a_full && (rd_addr2 == a_buf_addr)) ||
                      (b_full && (rd_addr2 == b_buf_addr)) ||
                      (rf_we  && (rd_addr2 == rf_waddr)));

    assign busy = a_full || b_full || rf_we;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter plus starvation and reset sequences.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr = '0, b_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        rf_we, hazard1, hazard2, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int av, aa, ad, bv, ba, bd, r1, r2;
        int e_ar, e_br, e_we, e_wa, e_wd, e_h1, e_h2, e_busy;
    } vec_t;

    vec_t vec [20];

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .hazard1  (hazard1),
        .hazard2  (hazard2),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        a_valid  = v.av[0];
        a_addr   = 5'(v.aa);
        a_data   = 32'(v.ad);
        b_valid  = v.bv[0];
        b_addr   = 5'(v.ba);
        b_data   = 32'(v.bd);
        rd_addr1 = 5'(v.r1);
        rd_addr2 = 5'(v.r2);
    endtask

    task automatic driveIdle();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        // av aa ad      bv ba bd     r1 r2 | ar br we wa wd       h1 h2 busy
        vec[0]  = '{1, 7, 'h1234, 0, 0, 0,     7, 0,  1, 1, 0, 0, 0,       0, 0, 0};
        vec[1]  = '{0, 0, 0,      0, 0, 0,     7, 0,  1, 1, 0, 0, 0,       1, 0, 1};
        vec[2]  = '{0, 0, 0,      0, 0, 0,     7, 0,  1, 1, 1, 7, 'h1234,  1, 0, 1};
        vec[3]  = '{0, 0, 0,      0, 0, 0,     7, 0,  1, 1, 0, 7, 'h1234,  0, 0, 0};
        vec[4]  = '{1, 3, 'hA,    1, 3, 'hB,   3, 7,  1, 1, 0, 7, 'h1234,  0, 0, 0};
        vec[5]  = '{0, 0, 0,      0, 0, 0,     3, 7,  1, 0, 0, 7, 'h1234,  1, 0, 1};
        vec[6]  = '{0, 0, 0,      0, 0, 0,     3, 7,  1, 1, 1, 3, 'hA,     1, 0, 1};
        vec[7]  = '{0, 0, 0,      0, 0, 0,     3, 7,  1, 1, 1, 3, 'hB,     1, 0, 1};
        vec[8]  = '{0, 0, 0,      0, 0, 0,     3, 7,  1, 1, 0, 3, 'hB,     0, 0, 0};
        vec[9]  = '{1, 0, 'h55,   1, 0, 'h66,  0, 3,  1, 1, 0, 3, 'hB,     0, 0, 0};
        vec[10] = '{0, 0, 0,      0, 0, 0,     0, 3,  1, 1, 0, 3, 'hB,     0, 0, 0};
        vec[11] = '{0, 0, 0,      0, 0, 0,     0, 3,  1, 1, 0, 3, 'hB,     0, 0, 0};
        vec[12] = '{1, 10, 'h100, 1, 11, 'h200, 10, 11, 1, 1, 0, 3, 'hB,    0, 0, 0};
        vec[13] = '{1, 10, 'h101, 1, 12, 'h201, 10, 11, 0, 1, 0, 3, 'hB,    1, 1, 1};
        vec[14] = '{1, 10, 'h101, 1, 13, 'h202, 10, 11, 0, 1, 1, 11, 'h200, 1, 1, 1};
        vec[15] = '{1, 10, 'h101, 0, 0, 0,     10, 11, 0, 1, 1, 12, 'h201, 1, 0, 1};
        vec[16] = '{1, 10, 'h101, 0, 0, 0,     10, 11, 1, 1, 1, 13, 'h202, 1, 0, 1};
        vec[17] = '{0, 0, 0,      0, 0, 0,     10, 11, 1, 1, 1, 10, 'h100, 1, 0, 1};
        vec[18] = '{0, 0, 0,      0, 0, 0,     10, 11, 1, 1, 1, 10, 'h101, 1, 0, 1};
        vec[19] = '{0, 0, 0,      0, 0, 0,     10, 11, 1, 1, 0, 10, 'h101, 0, 0, 0};

        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(vec[i]);
            #1;
            checkOutput($sformatf("row%0d.a_ready", i), int'(a_ready), vec[i].e_ar);
            checkOutput($sformatf("row%0d.b_ready", i), int'(b_ready), vec[i].e_br);
            checkOutput($sformatf("row%0d.rf_we", i), int'(rf_we), vec[i].e_we);
            checkOutput($sformatf("row%0d.rf_waddr", i), int'(rf_waddr), vec[i].e_wa);
            checkOutput($sformatf("row%0d.rf_wdata", i), int'(rf_wdata), vec[i].e_wd);
            checkOutput($sformatf("row%0d.hazard1", i), int'(hazard1), vec[i].e_h1);
            checkOutput($sformatf("row%0d.hazard2", i), int'(hazard2), vec[i].e_h2);
            checkOutput($sformatf("row%0d.busy", i), int'(busy), vec[i].e_busy);
        end

        // A parked at r9 while B streams to r5: exactly three B writes precede A's.
        begin
            int st_we   [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
            int st_addr [8] = '{0, 0, 5, 5, 5, 9, 5, 0};
            int st_data [8] = '{0, 0, 'h50, 'h51, 'h52, 'h900, 'h53, 0};
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                a_valid = (c == 0);
                a_addr  = 5'd9;
                a_data  = 32'h900;
                b_valid = (c <= 4);
                b_addr  = 5'd5;
                b_data  = 32'h50 + 32'(c);
                #1;
                if (c >= 1 && c <= 4)
                    checkOutput($sformatf("starve.c%0d.a_ready", c), int'(a_ready), (c == 4) ? 1 : 0);
                if (c == 4)
                    checkOutput("starve.c4.b_ready", int'(b_ready), 0);
                checkOutput($sformatf("starve.c%0d.rf_we", c), int'(rf_we), st_we[c]);
                if (st_we[c] != 0) begin
                    checkOutput($sformatf("starve.c%0d.rf_waddr", c), int'(rf_waddr), st_addr[c]);
                    checkOutput($sformatf("starve.c%0d.rf_wdata", c), int'(rf_wdata), st_data[c]);
                end
                if (c == 7)
                    checkOutput("starve.c7.busy", int'(busy), 0);
            end
        end

        // Reset while both buffers hold entries and a write is in flight.
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd20; a_data = 32'hAA;
        b_valid = 1'b1; b_addr = 5'd21; b_data = 32'hBB;
        @(negedge clk);
        a_valid = 1'b0;
        b_addr  = 5'd22; b_data = 32'hCC;
        @(negedge clk);
        driveIdle();
        rd_addr1 = 5'd20;
        rd_addr2 = 5'd22;
        #1;
        checkOutput("rstmid.pre.rf_we", int'(rf_we), 1);
        checkOutput("rstmid.pre.rf_waddr", int'(rf_waddr), 21);
        checkOutput("rstmid.pre.a_ready", int'(a_ready), 0);
        checkOutput("rstmid.pre.hazard2", int'(hazard2), 1);
        rst = 1'b0;
        #1;
        checkOutput("rstmid.rf_we", int'(rf_we), 0);
        checkOutput("rstmid.rf_waddr", int'(rf_waddr), 0);
        checkOutput("rstmid.rf_wdata", int'(rf_wdata), 0);
        checkOutput("rstmid.busy", int'(busy), 0);
        checkOutput("rstmid.hazard1", int'(hazard1), 0);
        checkOutput("rstmid.hazard2", int'(hazard2), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("rstpost.c%0d.rf_we", c), int'(rf_we), 0);
            checkOutput($sformatf("rstpost.c%0d.busy", c), int'(busy), 0);
            checkOutput($sformatf("rstpost.c%0d.a_ready", c), int'(a_ready), 1);
            checkOutput($sformatf("rstpost.c%0d.b_ready", c), int'(b_ready), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: ALU result (port A) and memory-load result (port B). Each side has a 1-entry holding buffer with valid/ready handshake. A registered write stage drives the register file's write enable, address and data. The block also flags read-after-write hazards for the two read addresses against pending writes.

Parameters:
DATA_W, 32, width of write data.
ADDR_W, 5, register address width (32 registers).
STARVE_LIMIT, 3, consecutive lost arbitration cycles after which port A is force-granted; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
a_valid  input  1  ALU writeback request.
a_ready  output  1  A holding buffer can accept this cycle.
a_addr  input  ADDR_W  ALU destination register.
a_data  input  DATA_W  ALU result.
b_valid  input  1  load writeback request.
b_ready  output  1  B holding buffer can accept this cycle.
b_addr  input  ADDR_W  load destination register.
b_data  input  DATA_W  load data.
rf_we  output  1  register-file write enable (registered).
rf_waddr  output  ADDR_W  register-file write address (registered).
rf_wdata  output  DATA_W  register-file write data (registered).
rd_addr1  input  ADDR_W  read address 1, for hazard check.
rd_addr2  input  ADDR_W  read address 2, for hazard check.
hazard1  output  1  rd_addr1 has a pending write (combinational).
hazard2  output  1  rd_addr2 has a pending write (combinational).
busy  output  1  any holding buffer full or rf_we high.

Behaviour:
- Reset (rst=0, asynchronous): both holding buffers empty, starve counter 0, age flag cleared; rf_we=0, rf_waddr=0, rf_wdata=0. Reset mid-operation discards all buffered writes.
- Handshake: a transfer occurs when valid=1 and ready=1 at a rising edge.
  - ready = buffer empty OR buffer granted this cycle (drain-and-refill in the same cycle is allowed).
  - valid may drop without a transfer; buffered data is stable until granted.
- Address 0: the transfer is accepted, but the entry is dropped and never asserts rf_we. It is not buffered and raises no hazard.
- Holding state per side: EMPTY -> FULL on accept (addr != 0). FULL -> EMPTY on grant, unless refilled the same cycle (stays FULL).
- Arbitration is evaluated every cycle over the FULL buffers; at most one grant per cycle.
  - Only one FULL: grant it.
  - Both FULL, same address: grant in arrival order via the age flag. Simultaneous arrival counts as A older. The later write therefore wins in the register file.
  - Both FULL, different addresses: grant B, unless starve counter >= STARVE_LIMIT, then grant A.
- Starve counter:
  - Increments when A is FULL and B is granted, saturating at 15.
  - Clears when A is granted or A is EMPTY.
- Write stage: on grant, rf_we<=1, rf_waddr<=entry addr, rf_wdata<=entry data at the same edge. With no grant, rf_we<=0 and addr/data hold their values.
- Latency: accept at edge N into an empty buffer; grant is evaluated in cycle N+1; rf_we is high during cycle N+2 (the register file commits at the end of N+2). Minimum 2 cycles. Sustained throughput is 1 write/cycle.
- Hazard: hazardK=1 if rd_addrK != 0 and rd_addrK equals any of:
  - the A buffer addr (FULL),
  - the B buffer addr (FULL),
  - rf_waddr while rf_we=1.
- busy = A FULL | B FULL | rf_we.

Decomposition:
- Shared package: DATA_W/ADDR_W constants, the zero-register address constant, the STARVE counter width (4 bits).
- One natural sub-module: wb_hold_buffer (1-entry valid/ready holding register with grant input), instantiated twice.
- Arbitration, starve counter, write stage and hazard logic stay in the top module.

Test Plan:
- Single A write: a_valid=1, a_addr=7, a_data=0x1234 for one cycle -> rf_we=1, rf_waddr=7, rf_wdata=0x1234 exactly 2 cycles later, single pulse; hazard1=1 for rd_addr1=7 while pending.
- Same-cycle A(addr 3, 0xA) and B(addr 3, 0xB) -> writes 0xA then 0xB on consecutive cycles; final rf_wdata=0xB.
- Starvation: B streams every cycle to addr 5, A held at addr 9, STARVE_LIMIT=3 -> A granted after exactly 3 B grants; a_ready returns high the same cycle.
- Zero register: a_valid=1, a_addr=0 -> a_ready=1, rf_we stays 0, hazard1=0 for rd_addr1=0, busy stays 0.
- Back-pressure: A and B both FULL, new a_valid held -> a_ready=0 until A is granted; no data loss; the order of rf writes matches the priority rules.
- Reset mid-operation: both buffers FULL and rf_we=1, assert rst=0 -> rf_we=0, busy=0, both ready=1 immediately after release; no stale write appears.
